// File: rtl/pcm_mem_slave.sv
// -----------------------------------------------------------------------------
// pcm_mem_slave
//
// Single-port word memory with byte-lane writes, a registered read path and a
// built-in clear engine that fills the whole array with INIT_VALUE.
//
// Ports
//   clk            rising-edge clock for all state
//   reset          asynchronous, active-low reset (memory contents untouched)
//   init           one-cycle pulse: start (or restart) a full-memory clear
//   address        word address of the access
//   chipselect     access request qualifier
//   clken          access clock enable; 0 freezes the access path
//   write          1 = write access, 0 = read access
//   writedata      write data
//   byteenable     write lane enables, bit0 = [7:0], bit1 = [15:8]
//   readdata       registered read data, holds between reads
//   readdatavalid  one-cycle strobe marking new readdata
//   clearing       high while the clear engine owns the memory
// -----------------------------------------------------------------------------
module pcm_mem_slave #(
    parameter int                ADDR_W     = 11,
    parameter int                DATA_W     = 16,
    parameter logic [DATA_W-1:0] INIT_VALUE = 16'h0000
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  init,
    input  logic [ADDR_W-1:0]     address,
    input  logic                  chipselect,
    input  logic                  clken,
    input  logic                  write,
    input  logic [DATA_W-1:0]     writedata,
    input  logic [DATA_W/8-1:0]   byteenable,
    output logic [DATA_W-1:0]     readdata,
    output logic                  readdatavalid,
    output logic                  clearing
);

    localparam int              LANES     = DATA_W / 8;
    localparam int              DEPTH     = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] LAST_ADDR = '1;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } state_t;

    state_t              r_state;
    state_t              w_state_next;
    logic [ADDR_W-1:0]   r_counter;
    logic [ADDR_W-1:0]   w_counter_next;

    logic                w_clearing;
    logic                w_accept;
    logic                w_read_accept;
    logic [ADDR_W-1:0]   w_mem_addr;
    logic [DATA_W-1:0]   w_mem_wdata;
    logic [LANES-1:0]    w_lane_we;
    logic [7:0]          r_rd_lane [LANES];
    logic                r_rvalid;

    // ------------------------------------------------------------------
    // Clear engine
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state   <= ST_IDLE;
            r_counter <= '0;
        end else begin
            r_state   <= w_state_next;
            r_counter <= w_counter_next;
        end
    end

    always_comb begin
        w_state_next   = r_state;
        w_counter_next = r_counter;
        case (r_state)
            ST_IDLE: begin
                if (init) begin
                    w_state_next   = ST_CLEAR;
                    w_counter_next = '0;
                end
            end
            ST_CLEAR: begin
                // A fresh init restarts the sweep so the full array is
                // cleared after the most recent request.
                if (init) begin
                    w_counter_next = '0;
                end else if (r_counter == LAST_ADDR) begin
                    // Stop after the last word; never wrap into a second pass.
                    w_state_next   = ST_IDLE;
                    w_counter_next = '0;
                end else begin
                    w_counter_next = r_counter + 1'b1;
                end
            end
            default: begin
                w_state_next   = ST_IDLE;
                w_counter_next = '0;
            end
        endcase
    end

    assign w_clearing = (r_state == ST_CLEAR);
    assign clearing   = w_clearing;

    // ------------------------------------------------------------------
    // Access path
    // ------------------------------------------------------------------
    // reset is folded in so no access can touch memory while held in reset.
    assign w_accept      = reset & chipselect & clken & ~w_clearing;
    assign w_read_accept = w_accept & ~write;

    // The clear engine owns the single write port while it runs.
    assign w_mem_addr  = w_clearing ? r_counter  : address;
    assign w_mem_wdata = w_clearing ? INIT_VALUE : writedata;

    // One 8-bit RAM per byte lane keeps the lane write enables independent.
    genvar gi;
    generate
        for (gi = 0; gi < LANES; gi++) begin : gen_lane
            logic [7:0] r_mem [DEPTH];

            assign w_lane_we[gi] = w_clearing | (w_accept & write & byteenable[gi]);

            always_ff @(posedge clk) begin
                if (w_lane_we[gi]) begin
                    r_mem[w_mem_addr] <= w_mem_wdata[gi*8 +: 8];
                end
            end

            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    r_rd_lane[gi] <= '0;
                end else if (w_read_accept) begin
                    r_rd_lane[gi] <= r_mem[address];
                end
            end

            assign readdata[gi*8 +: 8] = r_rd_lane[gi];
        end
    endgenerate

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_rvalid <= 1'b0;
        end else begin
            r_rvalid <= w_read_accept;
        end
    end

    assign readdatavalid = r_rvalid;

endmodule

// File: tb/tb_pcm_mem_slave.sv
// -----------------------------------------------------------------------------
// tb_pcm_mem_slave
//
// Directed bench for pcm_mem_slave. Inputs are driven on the falling edge and
// outputs are sampled 1 ns after the rising edge.
// -----------------------------------------------------------------------------
module tb_pcm_mem_slave;

    logic        clk = 1'b0;
    logic        reset;
    logic        init;
    logic [10:0] address;
    logic        chipselect;
    logic        clken;
    logic        write;
    logic [15:0] writedata;
    logic [1:0]  byteenable;
    logic [15:0] readdata;
    logic        readdatavalid;
    logic        clearing;

    int vectors     = 0;
    int miscompares = 0;
    bit trace       = 1'b1;

    pcm_mem_slave #(
        .ADDR_W     (11),
        .DATA_W     (16),
        .INIT_VALUE (16'h0000)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .init          (init),
        .address       (address),
        .chipselect    (chipselect),
        .clken         (clken),
        .write         (write),
        .writedata     (writedata),
        .byteenable    (byteenable),
        .readdata      (readdata),
        .readdatavalid (readdatavalid),
        .clearing      (clearing)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock cycle: drive on the falling edge, return 1 ns after the rising edge.
    task automatic cycle(input logic cs, input logic ce, input logic wr, input logic in,
                         input logic [10:0] a, input logic [15:0] d, input logic [1:0] be);
        @(negedge clk);
        chipselect = cs;
        clken      = ce;
        write      = wr;
        init       = in;
        address    = a;
        writedata  = d;
        byteenable = be;
        @(posedge clk);
        #1;
        if (trace)
            $display("t=%0t cs=%b ce=%b wr=%b init=%b addr=%h wd=%h be=%b -> rd=%h rv=%b clr=%b",
                     $time, cs, ce, wr, in, a, d, be, readdata, readdatavalid, clearing);
    endtask

    task automatic idle();
        cycle(1'b0, 1'b0, 1'b0, 1'b0, 11'h000, 16'h0000, 2'b00);
    endtask

    initial begin
        int c;
        int i;
        int bad_rv;
        int bad_hold;

        reset      = 1'b0;
        init       = 1'b0;
        address    = '0;
        chipselect = 1'b0;
        clken      = 1'b0;
        write      = 1'b0;
        writedata  = '0;
        byteenable = '0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_readdata", 32'(readdata), 32'h0000);
        check("rst_rvalid",   32'(readdatavalid), 32'h0);
        check("rst_clearing", 32'(clearing), 32'h0);
        @(negedge clk);
        reset = 1'b1;

        // Full write then back-to-back read of the same address
        cycle(1, 1, 1, 0, 11'h066, 16'h9999, 2'b11);
        check("wr_no_rvalid",  32'(readdatavalid), 32'h0);
        check("wr_rd_untouch", 32'(readdata), 32'h0000);
        cycle(1, 1, 0, 0, 11'h066, 16'h0000, 2'b00);
        check("rd_9999_data",  32'(readdata), 32'h9999);
        check("rd_9999_valid", 32'(readdatavalid), 32'h1);
        idle();
        check("idle_rvalid",   32'(readdatavalid), 32'h0);
        check("idle_hold",     32'(readdata), 32'h9999);

        // Byte-lane writes
        cycle(1, 1, 1, 0, 11'h066, 16'h00AB, 2'b01);
        cycle(1, 1, 0, 0, 11'h066, 16'h0000, 2'b00);
        check("be01_data",     32'(readdata), 32'h99AB);
        cycle(1, 1, 1, 0, 11'h066, 16'hFFFF, 2'b00);
        cycle(1, 1, 0, 0, 11'h066, 16'h0000, 2'b00);
        check("be00_data",     32'(readdata), 32'h99AB);
        check("be00_valid",    32'(readdatavalid), 32'h1);

        // Gated accesses
        cycle(1, 1, 1, 0, 11'h000, 16'h1234, 2'b11);
        cycle(1, 1, 0, 0, 11'h000, 16'h0000, 2'b00);
        check("rd_000_data",   32'(readdata), 32'h1234);
        cycle(1, 0, 0, 0, 11'h066, 16'h0000, 2'b00);
        check("clken0_rvalid", 32'(readdatavalid), 32'h0);
        check("clken0_hold",   32'(readdata), 32'h1234);
        cycle(0, 1, 0, 0, 11'h066, 16'h0000, 2'b00);
        check("cs0_rvalid",    32'(readdatavalid), 32'h0);
        check("cs0_hold",      32'(readdata), 32'h1234);
        cycle(1, 0, 1, 0, 11'h066, 16'h5555, 2'b11);
        cycle(1, 1, 0, 0, 11'h066, 16'h0000, 2'b00);
        check("clken0_wr_drop", 32'(readdata), 32'h99AB);

        cycle(1, 1, 1, 0, 11'h7FF, 16'hBEEF, 2'b11);
        cycle(1, 1, 0, 0, 11'h7FF, 16'h0000, 2'b00);
        check("rd_7ff_data",   32'(readdata), 32'hBEEF);

        // Clear, with a read in the same cycle as init (the read wins that cycle)
        cycle(1, 1, 0, 1, 11'h066, 16'h0000, 2'b00);
        check("init_rd_valid", 32'(readdatavalid), 32'h1);
        check("init_rd_data",  32'(readdata), 32'h99AB);
        check("init_clearing", 32'(clearing), 32'h1);
        trace    = 1'b0;
        c        = 1;
        i        = 0;
        bad_rv   = 0;
        bad_hold = 0;
        while (clearing && c < 5000) begin
            cycle(1, 1, (i % 2 == 0), 0, (i % 4 == 0) ? 11'h000 : 11'h7FF, 16'hAAAA, 2'b11);
            if (readdatavalid) bad_rv++;
            if (readdata !== 16'h99AB) bad_hold++;
            if (clearing) c++;
            i++;
        end
        trace = 1'b1;
        check("clear_len",     32'(c), 32'd2048);
        check("clear_rv_drop", 32'(bad_rv), 32'd0);
        check("clear_rd_hold", 32'(bad_hold), 32'd0);
        cycle(1, 1, 0, 0, 11'h000, 16'h0000, 2'b00);
        check("clr_000",       32'(readdata), 32'h0000);
        check("clr_000_valid", 32'(readdatavalid), 32'h1);
        cycle(1, 1, 0, 0, 11'h066, 16'h0000, 2'b00);
        check("clr_066",       32'(readdata), 32'h0000);
        cycle(1, 1, 0, 0, 11'h7FF, 16'h0000, 2'b00);
        check("clr_7ff",       32'(readdata), 32'h0000);

        // Re-pulse init at clear cycle 100
        trace = 1'b0;
        cycle(0, 0, 0, 1, 11'h000, 16'h0000, 2'b00);
        repeat (99) idle();
        check("repulse_pre",   32'(clearing), 32'h1);
        cycle(0, 0, 0, 1, 11'h000, 16'h0000, 2'b00);
        c = clearing ? 1 : 0;
        while (clearing && c < 5000) begin
            idle();
            if (clearing) c++;
        end
        trace = 1'b1;
        check("repulse_len",   32'(c), 32'd2048);

        // Reset in the middle of a clear
        cycle(1, 1, 1, 0, 11'h7FF, 16'hCAFE, 2'b11);
        cycle(1, 1, 1, 0, 11'h000, 16'h1111, 2'b11);
        cycle(1, 1, 0, 0, 11'h000, 16'h0000, 2'b00);
        check("pre_rst_data",  32'(readdata), 32'h1111);
        trace = 1'b0;
        cycle(0, 0, 0, 1, 11'h000, 16'h0000, 2'b00);
        repeat (49) idle();
        trace = 1'b1;
        check("mid_clear",     32'(clearing), 32'h1);
        #2;
        reset = 1'b0;
        #1;
        check("arst_readdata", 32'(readdata), 32'h0000);
        check("arst_clearing", 32'(clearing), 32'h0);
        check("arst_rvalid",   32'(readdatavalid), 32'h0);
        repeat (2) @(negedge clk);
        reset      = 1'b1;
        chipselect = 1'b1;
        clken      = 1'b1;
        write      = 1'b0;
        init       = 1'b0;
        address    = 11'h7FF;
        @(posedge clk);
        #1;
        $display("t=%0t first read after reset addr=7ff -> rd=%h rv=%b", $time, readdata, readdatavalid);
        check("post_rst_valid", 32'(readdatavalid), 32'h1);
        check("post_rst_7ff",   32'(readdata), 32'hCAFE);
        cycle(1, 1, 0, 0, 11'h000, 16'h0000, 2'b00);
        check("post_rst_000",   32'(readdata), 32'h0000);
        check("post_rst_clr",   32'(clearing), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
